rice_core_hazard_control: RTL and testbench

Pipeline interlock controller for the RV32 core. It sits beside the ID→EX operand forwarding path and decides when forwarding alone is insufficient: a load-use dependency, a slow data-memory response, or a control-flow redirect. It drives the stall, EX-bubble and flush controls consumed by the IF/ID/EX pipeline registers and the forwarding stage's wb holding register.

---
 rtl/rice_core_pkg.sv | 24 ++
 rtl/rice_core_hazard_control_if.sv | 42 ++++
 rtl/rice_core_flush_timer.sv | 30 +++
 rtl/rice_core_hazard_control.sv | 112 +++++++++++
 tb/tb_rice_core_hazard_control.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rice_core_pkg.sv
// Shared types and helpers for the rice core pipeline interlock logic.
package rice_core_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    FLUSH    = 2'd3
  } rice_core_hazard_state;

  localparam logic [1:0] HZ_IDLE     = IDLE;
  localparam logic [1:0] HZ_RUN      = RUN;
  localparam logic [1:0] HZ_MEM_WAIT = MEM_WAIT;
  localparam logic [1:0] HZ_FLUSH    = FLUSH;

  localparam int unsigned FLUSH_TIMER_W = 4;

  // Specifiers arrive zero-extended so one helper serves any RS width; x0 never hits.
  function automatic logic rice_core_load_use_hit(input logic [31:0] rs, input logic used,
                                                  input logic [31:0] rd);
    return used && (rs == rd) && (rd != 32'd0);
  endfunction

endpackage

// File: rtl/rice_core_hazard_control_if.sv
// Signal bundle between the IF/ID/EX pipeline and the hazard controller.
// RICE_HAZARD_STALL_COUNTER_EN adds the o_stall_cycles statistic.
interface rice_core_hazard_control_if #(
  parameter int RS_WIDTH = 5
);
  logic                i_enable;
  logic                i_id_valid;
  logic [RS_WIDTH-1:0] i_id_rs1;
  logic [RS_WIDTH-1:0] i_id_rs2;
  logic                i_id_rs1_used;
  logic                i_id_rs2_used;
  logic                i_ex_valid;
  logic                i_ex_load;
  logic [RS_WIDTH-1:0] i_ex_rd;
  logic                i_mem_ready;
  logic                i_flush_req;
  logic                o_stall;
  logic                o_ex_bubble;
  logic                o_flush;
`ifdef RICE_HAZARD_STALL_COUNTER_EN
  logic [31:0]         o_stall_cycles;
`endif

  modport master (
    output i_enable, i_id_valid, i_id_rs1, i_id_rs2, i_id_rs1_used, i_id_rs2_used,
           i_ex_valid, i_ex_load, i_ex_rd, i_mem_ready, i_flush_req,
    input  o_stall, o_ex_bubble, o_flush
`ifdef RICE_HAZARD_STALL_COUNTER_EN
           , o_stall_cycles
`endif
  );

  modport slave (
    input  i_enable, i_id_valid, i_id_rs1, i_id_rs2, i_id_rs1_used, i_id_rs2_used,
           i_ex_valid, i_ex_load, i_ex_rd, i_mem_ready, i_flush_req,
    output o_stall, o_ex_bubble, o_flush
`ifdef RICE_HAZARD_STALL_COUNTER_EN
           , o_stall_cycles
`endif
  );

endinterface

// File: rtl/rice_core_flush_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module rice_core_flush_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/rice_core_hazard_control.sv
// Pipeline interlock: load-use stall, memory-wait stall and redirect flush.
// RICE_HAZARD_STALL_COUNTER_EN adds a saturating stalled-cycle counter.
module rice_core_hazard_control
  import rice_core_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int RS_WIDTH     = 5
) (
  input logic                       i_clk,
  input logic                       i_rst_n,
  rice_core_hazard_control_if.slave hz
);

  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic [RS_WIDTH-1:0] id_rs1;
  logic [RS_WIDTH-1:0] id_rs2;
  logic [RS_WIDTH-1:0] ex_rd;
  logic                hazard;
  logic                stall;
  logic                ex_bubble;
  logic                flush;
  logic                timer_load;
  logic                timer_dec;
  logic                timer_done;

  assign id_rs1 = hz.i_id_rs1;
  assign id_rs2 = hz.i_id_rs2;
  assign ex_rd  = hz.i_ex_rd;

  // Equal rs1/rs2 simply OR into one dependency.
  assign hazard = hz.i_id_valid && hz.i_ex_valid && hz.i_ex_load &&
                  (rice_core_load_use_hit(32'(id_rs1), hz.i_id_rs1_used, 32'(ex_rd)) ||
                   rice_core_load_use_hit(32'(id_rs2), hz.i_id_rs2_used, 32'(ex_rd)));

  always_comb begin
    state_nxt  = state;
    stall      = 1'b0;
    ex_bubble  = 1'b0;
    flush      = 1'b0;
    timer_load = 1'b0;
    timer_dec  = 1'b0;
    case (state)
      HZ_IDLE: state_nxt = HZ_RUN;
      HZ_RUN: begin
        if (hz.i_flush_req) begin
          state_nxt  = HZ_FLUSH;
          timer_load = 1'b1;
        end else if (hazard) begin
          stall     = 1'b1;
          ex_bubble = 1'b1;
          state_nxt = HZ_MEM_WAIT;
        end
      end
      HZ_MEM_WAIT: begin
        stall     = !hz.i_mem_ready;
        ex_bubble = !hz.i_mem_ready;
        if (hz.i_mem_ready) state_nxt = HZ_RUN;
      end
      HZ_FLUSH: begin
        flush     = 1'b1;
        ex_bubble = 1'b1;
        if (hz.i_flush_req)  timer_load = 1'b1;
        else if (timer_done) state_nxt  = HZ_RUN;
        else                 timer_dec  = 1'b1;
      end
      default: state_nxt = HZ_IDLE;
    endcase
    // Outputs follow the current state; disable only redirects the next one.
    if (!hz.i_enable) state_nxt = HZ_IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= HZ_IDLE;
    else          state <= state_nxt;
  end

  rice_core_flush_timer #(.W(FLUSH_TIMER_W)) u_flush_timer (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .clear    (!hz.i_enable),
    .load     (timer_load),
    .load_val (FLUSH_TIMER_W'(FLUSH_CYCLES - 1)),
    .dec      (timer_dec),
    .done     (timer_done)
  );

  assign hz.o_stall     = stall;
  assign hz.o_ex_bubble = ex_bubble;
  assign hz.o_flush     = flush;

`ifdef RICE_HAZARD_STALL_COUNTER_EN
  logic [31:0] stall_cycles;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cycles <= '0;
    end else if (!hz.i_enable) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end

  assign hz.o_stall_cycles = stall_cycles;
`endif

  // A redirect cannot originate while the load is still outstanding.
  a_no_flush_in_mem_wait: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (state == HZ_MEM_WAIT) |-> !hz.i_flush_req);

endmodule

// File: tb/tb_rice_core_hazard_control.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
module tb_rice_core_hazard_control;
  localparam int FC = 2;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  // Reference model: enabled flag, outstanding-load flag, remaining flush cycles.
  bit     m_active;
  bit     m_waiting;
  int     m_flush_left;
  longint m_cnt;

  rice_core_hazard_control_if #(.RS_WIDTH(5)) hzif ();

  rice_core_hazard_control #(.FLUSH_CYCLES(FC), .RS_WIDTH(5)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .hz      (hzif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit ref_hazard();
    bit dep;
    dep = (hzif.i_id_rs1_used && (hzif.i_id_rs1 == hzif.i_ex_rd)) ||
          (hzif.i_id_rs2_used && (hzif.i_id_rs2 == hzif.i_ex_rd));
    return hzif.i_id_valid && hzif.i_ex_valid && hzif.i_ex_load && (hzif.i_ex_rd != 5'd0) && dep;
  endfunction

  task automatic model_outputs(output logic s, output logic b, output logic f);
    s = 1'b0; b = 1'b0; f = 1'b0;
    if (m_active) begin
      if (m_flush_left > 0) begin
        f = 1'b1; b = 1'b1;
      end else if (m_waiting) begin
        s = !hzif.i_mem_ready; b = !hzif.i_mem_ready;
      end else if (!hzif.i_flush_req && ref_hazard()) begin
        s = 1'b1; b = 1'b1;
      end
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_waiting = 0; m_flush_left = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    logic s, b, f;
    model_outputs(s, b, f);
    if (!hzif.i_enable) m_cnt = 0;
    else if (s && m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
    if (!hzif.i_enable) begin
      m_active = 0; m_waiting = 0; m_flush_left = 0;
    end else if (!m_active) begin
      m_active = 1;
    end else if (m_flush_left > 0) begin
      if (hzif.i_flush_req) m_flush_left = FC;
      else                  m_flush_left = m_flush_left - 1;
    end else if (m_waiting) begin
      if (hzif.i_mem_ready) m_waiting = 0;
    end else if (hzif.i_flush_req) begin
      m_flush_left = FC;
    end else if (ref_hazard()) begin
      m_waiting = 1;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    hzif.i_id_valid = 0; hzif.i_id_rs1 = 0; hzif.i_id_rs2 = 0;
    hzif.i_id_rs1_used = 0; hzif.i_id_rs2_used = 0; hzif.i_ex_valid = 0;
    hzif.i_ex_load = 0; hzif.i_ex_rd = 0; hzif.i_mem_ready = 0; hzif.i_flush_req = 0;
  endtask

  task automatic set_load_use(input logic [4:0] rd, input logic [4:0] rs1);
    hzif.i_ex_valid = 1; hzif.i_ex_load = 1; hzif.i_ex_rd = rd;
    hzif.i_id_valid = 1; hzif.i_id_rs1 = rs1; hzif.i_id_rs1_used = 1;
  endtask

  task automatic test_reset();
    rst_n = 0; hzif.i_enable = 0; clear_inputs(); model_reset();
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (hzif.o_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", hzif.o_stall); end
    n_cmp++; if (hzif.o_ex_bubble !== 1'b0) begin n_fail++; $display("FAIL reset_bubble: got %b want 0", hzif.o_ex_bubble); end
    n_cmp++; if (hzif.o_flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %b want 0", hzif.o_flush); end
`ifdef RICE_HAZARD_STALL_COUNTER_EN
    n_cmp++; if (hzif.o_stall_cycles !== 32'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", hzif.o_stall_cycles); end
`endif
    @(negedge clk);
    rst_n = 1; hzif.i_enable = 1;
    next_cycle();
  endtask

  task automatic test_load_use();
    set_load_use(5'd5, 5'd5);
    #1;
    n_cmp++; if (hzif.o_stall !== 1'b1) begin n_fail++; $display("FAIL lu_c0_stall: got %b want 1", hzif.o_stall); end
    n_cmp++; if (hzif.o_ex_bubble !== 1'b1) begin n_fail++; $display("FAIL lu_c0_bubble: got %b want 1", hzif.o_ex_bubble); end
    next_cycle();
    clear_inputs(); hzif.i_mem_ready = 1;
    #1;
    n_cmp++; if (hzif.o_stall !== 1'b0) begin n_fail++; $display("FAIL lu_c1_stall: got %b want 0", hzif.o_stall); end
    n_cmp++; if (hzif.o_ex_bubble !== 1'b0) begin n_fail++; $display("FAIL lu_c1_bubble: got %b want 0", hzif.o_ex_bubble); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_late_mem();
    logic want;
    set_load_use(5'd5, 5'd5);
    for (int i = 0; i < 6; i++) begin
      if (i == 1) clear_inputs();
      hzif.i_mem_ready = (i >= 4);
      want = (i < 4);
      #1;
      n_cmp++; if (hzif.o_stall !== want) begin n_fail++; $display("FAIL late_mem_stall[%0d]: got %b want %b", i, hzif.o_stall, want); end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_no_hazard();
    set_load_use(5'd0, 5'd0);
    #1;
    n_cmp++; if (hzif.o_stall !== 1'b0) begin n_fail++; $display("FAIL x0_stall: got %b want 0", hzif.o_stall); end
    next_cycle();
    clear_inputs();
    hzif.i_ex_valid = 1; hzif.i_ex_rd = 5'd5; hzif.i_id_valid = 1;
    hzif.i_id_rs2 = 5'd5; hzif.i_id_rs2_used = 1;
    #1;
    n_cmp++; if (hzif.o_stall !== 1'b0) begin n_fail++; $display("FAIL nonload_stall: got %b want 0", hzif.o_stall); end
    n_cmp++; if (hzif.o_ex_bubble !== 1'b0) begin n_fail++; $display("FAIL nonload_bubble: got %b want 0", hzif.o_ex_bubble); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_flush_priority();
    logic want;
    set_load_use(5'd7, 5'd7); hzif.i_flush_req = 1;
    #1;
    n_cmp++; if (hzif.o_stall !== 1'b0) begin n_fail++; $display("FAIL flushreq_stall: got %b want 0", hzif.o_stall); end
    n_cmp++; if (hzif.o_flush !== 1'b0) begin n_fail++; $display("FAIL flushreq_flush: got %b want 0", hzif.o_flush); end
    next_cycle();
    hzif.i_flush_req = 0;
    for (int i = 0; i <= FC; i++) begin
      if (i == FC) clear_inputs();
      want = (i < FC);
      #1;
      n_cmp++; if (hzif.o_flush !== want) begin n_fail++; $display("FAIL flush_len[%0d]: got %b want %b", i, hzif.o_flush, want); end
      n_cmp++; if (hzif.o_stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall[%0d]: got %b want 0", i, hzif.o_stall); end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_async_reset_mid_flush();
    hzif.i_flush_req = 1;
    next_cycle();
    hzif.i_flush_req = 0;
    #1;
    n_cmp++; if (hzif.o_flush !== 1'b1) begin n_fail++; $display("FAIL pre_rst_flush: got %b want 1", hzif.o_flush); end
    #1 rst_n = 0;
    #1;
    n_cmp++; if (hzif.o_flush !== 1'b0) begin n_fail++; $display("FAIL async_rst_flush: got %b want 0", hzif.o_flush); end
    n_cmp++; if (hzif.o_ex_bubble !== 1'b0) begin n_fail++; $display("FAIL async_rst_bubble: got %b want 0", hzif.o_ex_bubble); end
    model_reset();
    @(negedge clk);
    rst_n = 1;
    set_load_use(5'd3, 5'd3);
    #1;
    n_cmp++; if (hzif.o_stall !== 1'b0) begin n_fail++; $display("FAIL idle_after_rst_stall: got %b want 0", hzif.o_stall); end
    next_cycle();
    clear_inputs();
  endtask

`ifdef RICE_HAZARD_STALL_COUNTER_EN
  task automatic test_stall_counter();
    hzif.i_enable = 0;
    next_cycle();
    hzif.i_enable = 1;
    next_cycle();
    set_load_use(5'd9, 5'd9);
    next_cycle();
    clear_inputs();
    repeat (5) next_cycle();
    hzif.i_mem_ready = 1;
    next_cycle();
    clear_inputs();
    #1;
    n_cmp++; if (hzif.o_stall_cycles !== 32'd6) begin n_fail++; $display("FAIL stall_cnt: got %0d want 6", hzif.o_stall_cycles); end
    hzif.i_enable = 0;
    next_cycle();
    #1;
    n_cmp++; if (hzif.o_stall_cycles !== 32'd0) begin n_fail++; $display("FAIL stall_cnt_clr: got %0d want 0", hzif.o_stall_cycles); end
    hzif.i_enable = 1;
    next_cycle();
  endtask
`endif

  task automatic test_random();
    logic es, eb, ef;
    for (int i = 0; i < 3000; i++) begin
      hzif.i_enable      = ($urandom_range(0, 99) >= 4);
      hzif.i_id_valid    = ($urandom_range(0, 99) < 85);
      hzif.i_id_rs1      = 5'($urandom_range(0, 3));
      hzif.i_id_rs2      = 5'($urandom_range(0, 3));
      hzif.i_id_rs1_used = ($urandom_range(0, 99) < 70);
      hzif.i_id_rs2_used = ($urandom_range(0, 99) < 50);
      hzif.i_ex_valid    = ($urandom_range(0, 99) < 85);
      hzif.i_ex_load     = ($urandom_range(0, 99) < 50);
      hzif.i_ex_rd       = 5'($urandom_range(0, 3));
      hzif.i_mem_ready   = ($urandom_range(0, 99) < 40);
      hzif.i_flush_req   = ($urandom_range(0, 99) < 10);
      if (m_active && m_flush_left == 0 && m_waiting) hzif.i_flush_req = 0;
      model_outputs(es, eb, ef);
      #1;
      n_cmp++; if (hzif.o_stall !== es) begin n_fail++; $display("FAIL rnd_stall[%0d]: got %b want %b", i, hzif.o_stall, es); end
      n_cmp++; if (hzif.o_ex_bubble !== eb) begin n_fail++; $display("FAIL rnd_bubble[%0d]: got %b want %b", i, hzif.o_ex_bubble, eb); end
      n_cmp++; if (hzif.o_flush !== ef) begin n_fail++; $display("FAIL rnd_flush[%0d]: got %b want %b", i, hzif.o_flush, ef); end
`ifdef RICE_HAZARD_STALL_COUNTER_EN
      n_cmp++; if (hzif.o_stall_cycles !== 32'(m_cnt)) begin n_fail++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", i, hzif.o_stall_cycles, m_cnt); end
`endif
      next_cycle();
    end
    hzif.i_enable = 1;
    clear_inputs();
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_load_use();
    test_late_mem();
    test_no_hazard();
    test_flush_priority();
    test_async_reset_mid_flush();
`ifdef RICE_HAZARD_STALL_COUNTER_EN
    test_stall_counter();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
